// File: rtl/gray2bin_adapt.sv
// gray2bin_adapt: binarises DATA_W-bit gray pixels to 1-bit pixels.
// Three threshold modes are available: fixed, adaptive and hysteresis. The adaptive
// threshold is the mean of the previous complete frame. The output can be inverted.
// Configuration is latched on the sop pixel. The sideband is delayed by one cycle.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cfg_mode             0=FIXED 1=MEAN 2=HYST_FIXED 3=HYST_MEAN (latched at sop)
//   cfg_thr              threshold for the FIXED modes (latched at sop)
//   cfg_inv              invert the binary output (latched at sop)
//   din_sop/eop/vld/din  input pixel stream
//   dout_sop/eop/vld     input sideband delayed one cycle
//   dout                 binary pixel, holds its value while dout_vld is low
//   thr_active           threshold applied to the current frame
//   mean_busy            serial mean divider running
module gray2bin_adapt #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CNT_W   = 20,
   parameter int unsigned FIX_THR = 100,
   parameter int unsigned HYST    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_thr,
   input  logic              cfg_inv,
   input  logic              din_sop,
   input  logic              din_eop,
   input  logic              din_vld,
   input  logic [DATA_W-1:0] din,
   output logic              dout_sop,
   output logic              dout_eop,
   output logic              dout_vld,
   output logic              dout,
   output logic [DATA_W-1:0] thr_active,
   output logic              mean_busy
);

   localparam int unsigned SW  = DATA_W + CNT_W;
   localparam int unsigned SCW = $clog2(SW + 1);
   localparam logic [DATA_W-1:0] FixThr = DATA_W'(FIX_THR);
   localparam logic [DATA_W:0]   HystV  = (DATA_W + 1)'(HYST);
   localparam logic [DATA_W:0]   PixMax = {1'b0, {DATA_W{1'b1}}};
   localparam logic [CNT_W-1:0]  CntMax = '1;

   typedef enum logic [0:0] {StIdle, StAccum} acc_st_e;

   // ---------------- pixel path ----------------
   logic              hyst_q, inv_q, prev_b_q, dout_q;
   logic              dout_sop_q, dout_eop_q, dout_vld_q;
   logic [DATA_W-1:0] thr_q, mean_thr_q;

   logic              sop_px, eff_hyst, eff_inv, eff_prev, b;
   logic [DATA_W-1:0] eff_thr, hi, lo;
   logic [DATA_W:0]   thr_plus, thr_minus;

   // On the sop pixel the freshly presented configuration applies immediately.
   always_comb begin
      sop_px    = din_vld & din_sop;
      eff_hyst  = sop_px ? cfg_mode[1] : hyst_q;
      eff_inv   = sop_px ? cfg_inv : inv_q;
      eff_thr   = sop_px ? (cfg_mode[0] ? mean_thr_q : cfg_thr) : thr_q;
      eff_prev  = sop_px ? 1'b0 : prev_b_q;
      thr_plus  = {1'b0, eff_thr} + HystV;
      thr_minus = {1'b0, eff_thr} - HystV;
      hi        = (thr_plus > PixMax) ? PixMax[DATA_W-1:0] : thr_plus[DATA_W-1:0];
      lo        = ({1'b0, eff_thr} >= HystV) ? thr_minus[DATA_W-1:0] : '0;
      if (eff_hyst) begin
         if (din > hi)      b = 1'b1;
         else if (din < lo) b = 1'b0;
         else               b = eff_prev;
      end else begin
         b = din > eff_thr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hyst_q     <= 1'b0;
         inv_q      <= 1'b0;
         thr_q      <= FixThr;
         prev_b_q   <= 1'b0;
         dout_q     <= 1'b0;
         dout_sop_q <= 1'b0;
         dout_eop_q <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         dout_sop_q <= din_sop;
         dout_eop_q <= din_eop;
         dout_vld_q <= din_vld;
         if (din_vld) begin
            dout_q   <= b ^ eff_inv;
            prev_b_q <= b;
            if (din_sop) begin
               hyst_q <= cfg_mode[1];
               inv_q  <= cfg_inv;
               thr_q  <= eff_thr;
            end
         end
      end
   end

   // ---------------- frame accumulator ----------------
   acc_st_e          acc_st_q;
   logic [SW-1:0]    sum_q, acc_sum_nx;
   logic [CNT_W-1:0] cnt_q, acc_cnt_nx;
   logic             can_add, snap;

   always_comb begin
      can_add = (acc_st_q == StAccum) && (cnt_q != CntMax);
      if (sop_px) begin
         acc_sum_nx = SW'(din);
         acc_cnt_nx = CNT_W'(1);
      end else if (can_add) begin
         acc_sum_nx = sum_q + SW'(din);
         acc_cnt_nx = cnt_q + CNT_W'(1);
      end else begin
         acc_sum_nx = sum_q;
         acc_cnt_nx = cnt_q;
      end
      snap = din_vld & din_eop & (din_sop | (acc_st_q == StAccum));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_st_q <= StIdle;
         sum_q    <= '0;
         cnt_q    <= '0;
      end else if (din_vld) begin
         unique case (acc_st_q)
            StIdle: begin
               if (din_sop) begin
                  sum_q    <= acc_sum_nx;
                  cnt_q    <= acc_cnt_nx;
                  acc_st_q <= din_eop ? StIdle : StAccum;
               end
            end
            StAccum: begin
               sum_q <= acc_sum_nx;
               cnt_q <= acc_cnt_nx;
               if (din_eop) acc_st_q <= StIdle;
            end
            default: acc_st_q <= StIdle;
         endcase
      end
   end

   // ---------------- restoring divider ----------------
   logic             div_busy_q;
   logic [SCW-1:0]   div_step_q;
   logic [SW-1:0]    quo_q, quo_nx;
   logic [CNT_W-1:0] rem_q, rem_nx, dvs_q;
   logic [CNT_W:0]   rem_sh;
   logic             ge;

   always_comb begin
      rem_sh = {rem_q, quo_q[SW-1]};
      ge     = rem_sh >= {1'b0, dvs_q};
      rem_nx = ge ? CNT_W'(rem_sh - {1'b0, dvs_q}) : CNT_W'(rem_sh);
      quo_nx = {quo_q[SW-2:0], ge};
   end

   // A new snapshot wins over a completion in the same cycle; the old result is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_busy_q <= 1'b0;
         div_step_q <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         mean_thr_q <= FixThr;
      end else if (snap) begin
         div_busy_q <= 1'b1;
         div_step_q <= SCW'(SW);
         quo_q      <= acc_sum_nx;
         rem_q      <= '0;
         dvs_q      <= acc_cnt_nx;
      end else if (div_busy_q) begin
         quo_q      <= quo_nx;
         rem_q      <= rem_nx;
         div_step_q <= div_step_q - SCW'(1);
         if (div_step_q == SCW'(1)) begin
            div_busy_q <= 1'b0;
            mean_thr_q <= quo_nx[DATA_W-1:0];
         end
      end
   end

   assign dout_sop   = dout_sop_q;
   assign dout_eop   = dout_eop_q;
   assign dout_vld   = dout_vld_q;
   assign dout       = dout_q;
   assign thr_active = thr_q;
   assign mean_busy  = div_busy_q;

endmodule
